pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage load/bubble enables, flush redirect with
// fetch-drain handling for flushes that arrive during an icache miss,
// and saturating flush/stall performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_req,
  input  logic        flush_from_mem,
  input  logic [15:0] flush_target,
  input  logic        load_use,
  input  logic        icache_req,
  input  logic        icache_resp,
  input  logic        dcache_req,
  input  logic        dcache_resp,
  input  logic        perf_clr,
  output logic        load_if,
  output logic        load_id,
  output logic        load_ex,
  output logic        load_mem,
  output logic        load_wb,
  output logic        bubble_id,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        bubble_wb,
  output logic        stall,
  output logic        squash_fetch,
  output logic        pc_redirect_valid,
  output logic [15:0] pc_redirect,
  output logic [15:0] flush_count,
  output logic [15:0] stall_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] saved_target_q, saved_target_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic        mem_stall_s;
  logic        if_miss_s;
  logic        flush_acc_s;
  logic        stall_evt_s;
  logic [4:0]  load_s;      // {if, id, ex, mem, wb}
  logic [3:0]  bubble_s;    // {id, ex, mem, wb}
  logic        squash_s;
  logic        redir_v_s;
  logic [15:0] redir_pc_s;

  assign mem_stall_s = dcache_req & ~dcache_resp;
  assign if_miss_s   = icache_req & ~icache_resp;
  // A flush is only accepted when the back end is not frozen.
  assign flush_acc_s = flush_req & ~mem_stall_s;

  // Next-state, pipeline enables and redirect selection.
  always_comb begin
    state_d        = state_q;
    saved_target_d = saved_target_q;
    load_s         = 5'b11111;
    bubble_s       = 4'b0000;
    squash_s       = 1'b0;
    redir_v_s      = 1'b0;
    redir_pc_s     = 16'h0000;
    stall_evt_s    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          load_s      = 5'b00001;
          bubble_s    = 4'b0001;
          stall_evt_s = 1'b1;
        end else if (flush_req) begin
          bubble_s = {1'b1, 1'b1, flush_from_mem, 1'b0};
          if (if_miss_s) begin
            // Fetch in flight: redirect only after its response is discarded.
            saved_target_d = flush_target;
            state_d        = DRAIN;
          end else begin
            redir_v_s  = 1'b1;
            redir_pc_s = flush_target;
          end
        end else if (load_use) begin
          load_s      = 5'b00111;
          bubble_s    = 4'b0100;
          stall_evt_s = 1'b1;
        end else if (if_miss_s) begin
          load_s      = 5'b01111;
          bubble_s    = 4'b1000;
          stall_evt_s = 1'b1;
        end else begin
          load_s = 5'b11111;
        end
      end
      DRAIN: begin
        // Pipeline enables: hold IF while the stale fetch drains.
        if (mem_stall_s) begin
          load_s      = 5'b00001;
          bubble_s    = 4'b0001;
          stall_evt_s = 1'b1;
        end else if (flush_req) begin
          load_s      = 5'b01111;
          bubble_s    = {1'b1, 1'b1, flush_from_mem, 1'b0};
          stall_evt_s = 1'b1;
        end else if (load_use) begin
          load_s      = 5'b00111;
          bubble_s    = 4'b1100;
          stall_evt_s = 1'b1;
        end else begin
          load_s      = 5'b01111;
          bubble_s    = 4'b1000;
          stall_evt_s = 1'b1;
        end
        // Redirect/squash proceeds regardless of a back-end stall.
        if (icache_resp) begin
          squash_s   = 1'b1;
          redir_v_s  = 1'b1;
          redir_pc_s = flush_acc_s ? flush_target : saved_target_q;
          state_d    = RUN;
        end else if (flush_acc_s) begin
          saved_target_d = flush_target;
        end else begin
          saved_target_d = saved_target_q;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    flush_count_d = flush_count_q;
    stall_count_d = stall_count_q;
    if (perf_clr) begin
      flush_count_d = 16'h0000;
      stall_count_d = 16'h0000;
    end else begin
      if (flush_acc_s && (flush_count_q != 16'hFFFF)) begin
        flush_count_d = flush_count_q + 16'h0001;
      end else begin
        flush_count_d = flush_count_q;
      end
      if (stall_evt_s && (stall_count_q != 16'hFFFF)) begin
        stall_count_d = stall_count_q + 16'h0001;
      end else begin
        stall_count_d = stall_count_q;
      end
    end
  end

  // State, saved redirect target and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      saved_target_q <= 16'h0000;
      flush_count_q  <= 16'h0000;
      stall_count_q  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      saved_target_q <= saved_target_d;
      flush_count_q  <= flush_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  // Force safe control values for as long as reset is held.
  always_comb begin
    if (!reset_n) begin
      {load_if, load_id, load_ex, load_mem, load_wb} = 5'b00000;
      {bubble_id, bubble_ex, bubble_mem, bubble_wb} = 4'b1111;
      stall             = 1'b0;
      squash_fetch      = 1'b0;
      pc_redirect_valid = 1'b0;
      pc_redirect       = 16'h0000;
    end else begin
      {load_if, load_id, load_ex, load_mem, load_wb} = load_s;
      {bubble_id, bubble_ex, bubble_mem, bubble_wb} = bubble_s;
      stall             = mem_stall_s;
      squash_fetch      = squash_s;
      pc_redirect_valid = redir_v_s;
      pc_redirect       = redir_pc_s;
    end
  end

  assign flush_count = flush_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle control vectors
// checked through a scoreboard queue, plus directed multi-cycle sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_req, flush_from_mem, load_use;
  logic [15:0] flush_target;
  logic        icache_req, icache_resp, dcache_req, dcache_resp, perf_clr;
  logic        load_if, load_id, load_ex, load_mem, load_wb;
  logic        bubble_id, bubble_ex, bubble_mem, bubble_wb;
  logic        stall, squash_fetch, pc_redirect_valid;
  logic [15:0] pc_redirect, flush_count, stall_count;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .flush_req(flush_req), .flush_from_mem(flush_from_mem),
    .flush_target(flush_target), .load_use(load_use),
    .icache_req(icache_req), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .perf_clr(perf_clr),
    .load_if(load_if), .load_id(load_id), .load_ex(load_ex),
    .load_mem(load_mem), .load_wb(load_wb),
    .bubble_id(bubble_id), .bubble_ex(bubble_ex),
    .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
    .stall(stall), .squash_fetch(squash_fetch),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .flush_count(flush_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ctl = {load_if,id,ex,mem,wb, bubble_id,ex,mem,wb, stall, squash, redir_valid}
  typedef struct {
    logic        flush;
    logic        fm;
    logic [15:0] tgt;
    logic        lu;
    logic        ireq;
    logic        iresp;
    logic        dreq;
    logic        dresp;
    logic [11:0] ctl;
    logic [15:0] pc;
  } vec_t;

  typedef struct {
    logic [11:0] ctl;
    logic [15:0] pc;
    int          idx;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  function automatic logic [11:0] ctl_now();
    return {load_if, load_id, load_ex, load_mem, load_wb,
            bubble_id, bubble_ex, bubble_mem, bubble_wb,
            stall, squash_fetch, pc_redirect_valid};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic fl, input logic fm, input logic [15:0] tgt,
                       input logic lu, input logic iq, input logic ir,
                       input logic dq, input logic dr, input logic pc);
    flush_req = fl; flush_from_mem = fm; flush_target = tgt; load_use = lu;
    icache_req = iq; icache_resp = ir; dcache_req = dq; dcache_resp = dr;
    perf_clr = pc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_cyc(input string nm, input logic [11:0] ctl, input logic [15:0] pc);
    @(negedge clk);
    chk({nm, "_ctl"}, {20'h0, ctl_now()}, {20'h0, ctl});
    chk({nm, "_pc"}, {16'h0, pc_redirect}, {16'h0, pc});
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0, 12'b11111_0000_000, 16'h0000};
    vecs[1]  = '{1'b1,1'b0,16'h1234,1'b0,1'b0,1'b0,1'b0,1'b0, 12'b11111_1100_001, 16'h1234};
    vecs[2]  = '{1'b1,1'b1,16'h0ABC,1'b0,1'b0,1'b0,1'b0,1'b0, 12'b11111_1110_001, 16'h0ABC};
    vecs[3]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0, 12'b00111_0100_000, 16'h0000};
    vecs[4]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0, 12'b01111_1000_000, 16'h0000};
    vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b0, 12'b11111_0000_000, 16'h0000};
    vecs[6]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0, 12'b00001_0001_100, 16'h0000};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b1, 12'b11111_0000_000, 16'h0000};
    vecs[8]  = '{1'b1,1'b1,16'h5555,1'b1,1'b1,1'b0,1'b1,1'b0, 12'b00001_0001_100, 16'h0000};
    vecs[9]  = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0,1'b0,1'b0, 12'b00111_0100_000, 16'h0000};
    vecs[10] = '{1'b1,1'b0,16'h00F0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'b11111_1100_001, 16'h00F0};

    // Reset with busy inputs: outputs must be forced safe.
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cyc("reset", 12'b00000_1111_000, 16'h0000);
    chk("reset_fcnt", {16'h0, flush_count}, 32'h0);
    chk("reset_scnt", {16'h0, stall_count}, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    idle();

    // Table vectors through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      drive(vecs[i].flush, vecs[i].fm, vecs[i].tgt, vecs[i].lu, vecs[i].ireq,
            vecs[i].iresp, vecs[i].dreq, vecs[i].dresp, 1'b0);
      sb.push_back('{vecs[i].ctl, vecs[i].pc, i});
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("vec%0d_ctl", e.idx), {20'h0, ctl_now()}, {20'h0, e.ctl});
        chk($sformatf("vec%0d_pc", e.idx), {16'h0, pc_redirect}, {16'h0, e.pc});
      end else begin
        chk("sb_empty", 32'h1, 32'h0);
      end
    end

    // Flush with idle icache: same-cycle redirect, counter 1 afterwards.
    next_cycle(); idle(); perf_clr = 1'b1;
    next_cycle();
    drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s1_flush", 12'b11111_1100_001, 16'h1234);
    next_cycle(); idle();
    @(negedge clk);
    chk("s1_fcnt", {16'h0, flush_count}, 32'h1);

    // Flush during a 3-cycle icache miss: drain then squash and redirect.
    next_cycle();
    drive(1'b1, 1'b0, 16'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s2_flush", 12'b11111_1100_000, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s2_drain", 12'b01111_1000_000, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cyc("s2_resp", 12'b01111_1000_011, 16'h2000);
    next_cycle(); idle();
    chk_cyc("s2_run", 12'b11111_0000_000, 16'h0000);

    // 4-cycle dcache access with load_use and flush held during the stall.
    perf_clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b1, 1'b0, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_cyc($sformatf("s3_stall%0d", c), 12'b00001_0001_100, 16'h0000);
    end
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_cyc("s3_done", 12'b11111_0000_000, 16'h0000);
    next_cycle(); idle();
    @(negedge clk);
    chk("s3_scnt", {16'h0, stall_count}, 32'h3);
    chk("s3_fcnt", {16'h0, flush_count}, 32'h0);

    // Single-cycle load_use bubble, then free flow.
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s4_lu", 12'b00111_0100_000, 16'h0000);
    next_cycle(); idle();
    chk_cyc("s4_after", 12'b11111_0000_000, 16'h0000);

    // Flush from MEM while draining, then response redirects to new target.
    next_cycle();
    drive(1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s5_enter", 12'b11111_1100_000, 16'h0000);
    next_cycle();
    drive(1'b1, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cyc("s5_memflush", 12'b01111_1110_000, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cyc("s5_resp", 12'b01111_1000_011, 16'h0300);
    next_cycle(); idle();
    chk_cyc("s5_run", 12'b11111_0000_000, 16'h0000);

    // Reset while draining abandons the pending redirect.
    next_cycle();
    drive(1'b1, 1'b0, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle(); idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cyc("s6_noquash", 12'b11111_0000_000, 16'h0000);

    // Stall counter saturation and clear priority.
    next_cycle(); idle(); perf_clr = 1'b1;
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    @(negedge clk);
    chk("s7_preload", {16'h0, stall_count}, 32'hFFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s7_sat", {16'h0, stall_count}, 32'hFFFF);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    idle();
    @(negedge clk);
    chk("s7_clr", {16'h0, stall_count}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
